edca_backoff_countdown: RTL

EDCA_BACKOFF_COUNTDOWN -- requirements
Module: edca_backoff_countdown

---
 rtl/edca_backoff_countdown.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/edca_backoff_countdown.sv
// edca_backoff_countdown
//
// EDCA backoff engine. A slot count is loaded while IDLE. The block then
// waits AIFSN idle slots (AIFS), counts the loaded slots down on further idle
// slots (COUNT), and issues a one-cycle grant pulse (GRANT). A busy medium
// discards the partial slot and restarts AIFS with the remaining count frozen.
//
// Parameters:
//   SLOT_CYCLES  clock cycles per backoff slot (2..255)
//   AIFSN        idle slots required before countdown (1..15)
//   CNT_W        width of the slot counter
//
// Ports:
//   ap_clk        clock, rising edge
//   ap_rst        asynchronous active-high reset
//   load_valid    a new backoff slot count is offered
//   load_ready    high only in IDLE; load accepted when valid & ready
//   load_slots    backoff slot count to load
//   medium_idle   CCA idle, already synchronous to ap_clk
//   abort         cancels the backoff; highest priority
//   grant         one-cycle pulse: transmit opportunity won
//   busy          high whenever state is not IDLE
//   slots_left    remaining slot count
//   freeze_count  (only with EDCA_BACKOFF_STATS_EN) saturating count of
//                 COUNT-to-AIFS freezes since the last load
//
// Optional feature macro: EDCA_BACKOFF_STATS_EN

module edca_backoff_countdown #(
    parameter int SLOT_CYCLES = 20,
    parameter int AIFSN       = 2,
    parameter int CNT_W       = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [CNT_W-1:0] load_slots,
    input  logic             medium_idle,
    input  logic             abort,
    output logic             grant,
    output logic             busy,
    output logic [CNT_W-1:0] slots_left
`ifdef EDCA_BACKOFF_STATS_EN
    ,
    output logic [7:0]       freeze_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AIFS  = 2'd1,
        COUNT = 2'd2,
        GRANT = 2'd3
    } state_t;

    localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES - 1);
    localparam logic [3:0] AIFS_LAST = 4'(AIFSN - 1);

    state_t     state;
    logic [7:0] slot_timer;
    logic [3:0] aifs_cnt;
    logic       slot_done;
    logic       load_accept;

    assign load_ready  = (state == IDLE);
    assign busy        = (state != IDLE);
    // Abort outranks everything, including a load offered in IDLE.
    assign load_accept = load_valid && load_ready && !abort;
    // A slot completes on the last of SLOT_CYCLES consecutive idle cycles.
    assign slot_done   = medium_idle && (slot_timer == SLOT_LAST);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            slots_left <= '0;
            slot_timer <= '0;
            aifs_cnt   <= '0;
        end else begin
            grant <= 1'b0;
            if (abort) begin
                // slots_left is deliberately retained on abort.
                state      <= IDLE;
                slot_timer <= '0;
                aifs_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_accept) begin
                            slots_left <= load_slots;
                            slot_timer <= '0;
                            aifs_cnt   <= '0;
                            state      <= AIFS;
                        end
                    end
                    AIFS: begin
                        if (!medium_idle) begin
                            slot_timer <= '0;
                            aifs_cnt   <= '0;
                        end else if (slot_done) begin
                            slot_timer <= '0;
                            if (aifs_cnt == AIFS_LAST) begin
                                aifs_cnt <= '0;
                                if (slots_left == '0) begin
                                    state <= GRANT;
                                    grant <= 1'b1;
                                end else begin
                                    state <= COUNT;
                                end
                            end else begin
                                aifs_cnt <= aifs_cnt + 4'd1;
                            end
                        end else begin
                            slot_timer <= slot_timer + 8'd1;
                        end
                    end
                    COUNT: begin
                        // COUNT is only entered with slots_left >= 1 and left
                        // when it reaches 0, so the decrement cannot underflow.
                        if (!medium_idle) begin
                            slot_timer <= '0;
                            aifs_cnt   <= '0;
                            state      <= AIFS;
                        end else if (slot_done) begin
                            slot_timer <= '0;
                            slots_left <= slots_left - 1'b1;
                            if (slots_left == CNT_W'(1)) begin
                                state <= GRANT;
                                grant <= 1'b1;
                            end
                        end else begin
                            slot_timer <= slot_timer + 8'd1;
                        end
                    end
                    GRANT: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef EDCA_BACKOFF_STATS_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            freeze_count <= '0;
        end else if (load_accept) begin
            freeze_count <= '0;
        end else if (!abort && (state == COUNT) && !medium_idle
                     && (freeze_count != 8'hFF)) begin
            freeze_count <= freeze_count + 8'd1;
        end
    end
`endif

endmodule
